// File: rtl/rst_seq_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
// The bench imports this package as well, so both sides agree on the state encoding.
package rst_seq_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S_HOLD = 2'd0,
    S_LOCK = 2'd1,
    S_REL  = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Lock/soft-reset handshake and per-domain reset bundle of the reset sequencer.
interface rst_seq_ctrl_if #(
  parameter int P_NUM_DOM = 3
);
  import rst_seq_ctrl_pkg::*;

  logic                 i_locked;
  logic                 i_soft_rst_req;
  logic                 o_soft_rst_ack;
  logic [P_NUM_DOM-1:0] o_rst;
  logic                 o_ready;
  logic [ST_W-1:0]      o_state;

  modport master (
    output i_locked,
    output i_soft_rst_req,
    input  o_soft_rst_ack,
    input  o_rst,
    input  o_ready,
    input  o_state
  );

  modport slave (
    input  i_locked,
    input  i_soft_rst_req,
    output o_soft_rst_ack,
    output o_rst,
    output o_ready,
    output o_state
  );

endinterface

// File: rtl/rst_lock_filter.sv
// Qualifies i_locked: pulses o_stable after P_LOCK_STABLE consecutive locked cycles while enabled.
module rst_lock_filter #(
  parameter int P_LOCK_STABLE = 8,
  parameter int P_CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_locked,
  output logic o_stable
);

  localparam logic [P_CNT_W-1:0] LOCK_LAST = P_CNT_W'(P_LOCK_STABLE - 1);

  logic [P_CNT_W-1:0] cnt_reg;
  logic [P_CNT_W-1:0] cnt_next;

  assign o_stable = i_en && i_locked && (cnt_reg == LOCK_LAST);

  // Disabling the filter (leaving S_LOCK) restarts the qualification from zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (!i_en || !i_locked || o_stable) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, waits for a stable lock, then releases
// domains in index order with a fixed gap; soft resets are acknowledged on return to S_RUN.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int P_NUM_DOM     = 3,
  parameter int P_HOLD_CYCLE  = 16,
  parameter int P_LOCK_STABLE = 8,
  parameter int P_GAP_CYCLE   = 4,
  parameter int P_CNT_W       = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  rst_seq_ctrl_if.slave bus
);

  localparam int                  IDX_W     = idx_width(P_NUM_DOM);
  localparam logic [P_CNT_W-1:0] HOLD_LAST = P_CNT_W'(P_HOLD_CYCLE - 1);
  localparam logic [P_CNT_W-1:0] GAP_LAST  = P_CNT_W'(P_GAP_CYCLE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(P_NUM_DOM - 1);

  state_e               state_reg, state_next;
  logic [P_CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 pend_reg, pend_next;
  logic [P_NUM_DOM-1:0] rst_reg, rst_next;
  logic                 ready_reg, ready_next;
  logic                 ack_reg, ack_next;

  logic                 lock_stable;
  logic                 lock_lost;
  logic                 req_take;
  logic [P_NUM_DOM-1:0] rel_mask;

  rst_lock_filter #(
    .P_LOCK_STABLE (P_LOCK_STABLE),
    .P_CNT_W       (P_CNT_W)
  ) u_lock_filter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (state_reg == S_LOCK),
    .i_locked (bus.i_locked),
    .o_stable (lock_stable)
  );

  // One-hot mask of the domain currently due for release.
  generate
    for (genvar gi = 0; gi < P_NUM_DOM; gi++) begin : g_rel_mask
      assign rel_mask[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign lock_lost = !bus.i_locked && ((state_reg == S_REL) || (state_reg == S_RUN));
  // The cycle carrying the ack still sees the old request level, so it must not restart.
  assign req_take  = (state_reg == S_RUN) && bus.i_soft_rst_req && !ack_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    pend_next  = pend_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;
    ack_next   = 1'b0;

    case (state_reg)
      S_HOLD: begin
        rst_next   = '1;
        ready_next = 1'b0;
        if (cnt_reg == HOLD_LAST) begin
          state_next = S_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_LOCK: begin
        if (lock_stable) begin
          state_next = S_REL;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      S_REL: begin
        if (cnt_reg == GAP_LAST) begin
          rst_next = rst_reg & ~rel_mask;
          cnt_next = '0;
          idx_next = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = S_RUN;
            ready_next = 1'b1;
            idx_next   = '0;
            ack_next   = pend_reg;
            pend_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        rst_next   = '0;
        ready_next = 1'b1;
      end
      default: begin
        state_next = S_HOLD;
      end
    endcase

    // Any restart asserts every domain together; a pending request survives it.
    if (lock_lost || req_take) begin
      state_next = S_HOLD;
      cnt_next   = '0;
      idx_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
      ack_next   = 1'b0;
      pend_next  = pend_reg || req_take;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_HOLD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      pend_reg  <= 1'b0;
      rst_reg   <= '1;
      ready_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      pend_reg  <= pend_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
      ack_reg   <= ack_next;
    end
  end

  assign bus.o_rst          = rst_reg;
  assign bus.o_ready        = ready_reg;
  assign bus.o_soft_rst_ack = ack_reg;
  assign bus.o_state        = state_reg;

endmodule
